// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the ALU execute stage and the
// sequencing controller that feeds it.
package alu_pkg;

  // Opcode encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Bit positions inside the 4-bit {V,C,N,Z} flag vector
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  localparam int FLAGS_W = 4;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Purely combinational ALU: result and {V,C,N,Z} flags from a, b and opcode.
// Arithmetic is evaluated one bit wider than WIDTH so the top bit is the carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic           carry;
  logic           ovf;

  // Opcode decode, arithmetic and flag generation
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    sum    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    result = '0;
    flags  = '0;

    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[MSB:0];
        carry  = sum[WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Two's-complement subtract: carry out set means no borrow (a >= b).
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[MSB:0];
        carry  = sum[WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase

    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[MSB];
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule : alu_core

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined ALU execute stage with valid/ready on both sides,
// full backpressure, a saturating completed-op counter and a sticky overflow.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [CNT_W-1:0]   op_count,
  output logic               ovf_sticky,
  input  logic               clr_sticky
);

  // Stage S1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;

  // Combinational ALU output feeding the output registers
  logic [WIDTH-1:0]   core_result;
  logic [FLAGS_W-1:0] core_flags;

  logic adv1;
  logic adv2;
  logic out_fire;

  // The output stage moves when empty or drained; S1 moves when empty or S2 moves.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_fire = out_valid && out_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  // S1: capture operands and opcode whenever the stage advances
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end
  end

  // S2: register the ALU result; data holds while a beat waits for the consumer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= core_result;
        out_flags  <= core_flags;
      end
    end
  end

  // Status: saturating count of completed beats and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (out_fire && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (out_fire && out_flags[FLG_V]) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule : alu_exec_stage

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed ALU cases, sticky overflow,
// backpressure streaming, mid-flight reset and counter saturation.
module tb_alu_exec_stage;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  typedef struct {
    logic [5:0] res;
    logic [3:0] flg;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_a;
  logic [5:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] op_count;
  logic       ovf_sticky;
  logic       clr_sticky;

  // Second instance with a 2-bit counter to exercise saturation
  logic       in_ready2;
  logic       out_valid2;
  logic [5:0] out_result2;
  logic [3:0] out_flags2;
  logic [1:0] op_count2;
  logic       ovf_sticky2;

  int   checks = 0;
  int   errors = 0;
  exp_t scb[$];
  logic saw_stall;

  logic       held_valid = 1'b0;
  logic [5:0] held_res;
  logic [3:0] held_flg;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(6), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .op_count   (op_count),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  alu_exec_stage #(.WIDTH(6), .CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_result (out_result2),
    .out_flags  (out_flags2),
    .op_count   (op_count2),
    .ovf_sticky (ovf_sticky2),
    .clr_sticky (clr_sticky)
  );

  // Independent reference: integer arithmetic, flags packed {V,C,N,Z}
  function automatic exp_t model(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    exp_t e;
    int ua, ub, sa, sb, s, sv;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[5] ? ua - 64 : ua;
    sb = b[5] ? ub - 64 : ub;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      ADD: begin
        s = ua + ub; sv = sa + sb;
        e.res = 6'(s); c = (s > 63); v = (sv > 31) || (sv < -32);
      end
      SUB: begin
        s = ua - ub; sv = sa - sb;
        e.res = 6'(s); c = (ua >= ub); v = (sv > 31) || (sv < -32);
      end
      AND:     e.res = a & b;
      default: e.res = a | b;
    endcase
    e.flg = {v, c, e.res[5], (e.res == 6'd0)};
    return e;
  endfunction

  // Scoreboard monitor: compare each output transfer and check held outputs stay put
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid) begin
        checks++;
        if (out_result !== held_res || out_flags !== held_flg) begin
          errors++;
          $display("FAIL hold_stable: got res=%b flg=%b, held res=%b flg=%b",
                   out_result, out_flags, held_res, held_flg);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (scb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: res=%b flg=%b with empty scoreboard", out_result, out_flags);
        end else begin
          e = scb.pop_front();
          if (out_result !== e.res || out_flags !== e.flg) begin
            errors++;
            $display("FAIL result: got res=%b flg=%b, expected res=%b flg=%b",
                     out_result, out_flags, e.res, e.flg);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_res   = out_result;
      held_flg   = out_flags;
    end
  end

  // Present one beat and hold it until accepted; expected value queued on acceptance
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                      input logic [5:0] exp_res, input logic [3:0] exp_flg);
    bit accepted = 1'b0;
    int waited = 0;
    exp_t e;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else saw_stall = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    if (accepted) begin
      e.res = exp_res; e.flg = exp_flg;
      scb.push_back(e);
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
  endtask

  task automatic send_model(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    exp_t e;
    e = model(a, b, op);
    send(a, b, op, e.res, e.flg);
  endtask

  // Wait for every queued result to leave the DUT (out_ready must be high)
  task automatic wait_drain();
    int n = 0;
    while ((scb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (scb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, out_valid=%b, expected 0 pending", scb.size(), out_valid);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    scb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 6'd0 || out_flags !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b res=%b flg=%b, expected 0 0 0", out_valid, out_result, out_flags);
    end
    checks++;
    if (op_count !== 8'd0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: op_count=%0d sticky=%b, expected 0 0", op_count, ovf_sticky);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  // T1: ADD with latency check; result visible after the second register edge
  task automatic test_add();
    out_ready = 1'b1;
    send(6'b101010, 6'b010101, ADD, 6'b111111, 4'b0010);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one edge after accept, expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 6'b111111) begin
      errors++;
      $display("FAIL latency_arrive: valid=%b res=%b, expected 1 111111", out_valid, out_result);
    end
    wait_drain();
  endtask

  // T2: SUB carry/borrow, signed SUB overflow, and the logic ops
  task automatic test_sub_logic();
    out_ready = 1'b1;
    send(6'b111100, 6'b000011, SUB, 6'b111001, 4'b0110);
    send(6'b000001, 6'b000010, SUB, 6'b111111, 4'b0010);
    send(6'b100000, 6'b000001, SUB, 6'b011111, 4'b1100);
    send(6'b101010, 6'b011110, AND, 6'b001010, 4'b0000);
    send(6'b100000, 6'b000001, OR,  6'b100001, 4'b0010);
    send(6'b000000, 6'b000000, OR,  6'b000000, 4'b0001);
    wait_drain();
  endtask

  // T3: zero flag, ADD overflow, sticky set/clear and set-wins-over-clear
  task automatic test_flags_sticky();
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear_initial: got %b, expected 0", ovf_sticky);
    end
    send(6'b000000, 6'b000000, ADD, 6'b000000, 4'b0001);
    wait_drain();
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_no_ovf: got %b, expected 0", ovf_sticky);
    end
    send(6'b011111, 6'b000001, ADD, 6'b100000, 4'b1010);
    wait_drain();
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b, expected 1", ovf_sticky);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b, expected 0", ovf_sticky);
    end
    // Park an overflow beat at the output, then release it while clearing
    out_ready = 1'b0;
    send(6'b011111, 6'b000001, ADD, 6'b100000, 4'b1010);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_parked: valid=%b sticky=%b, expected 1 0", out_valid, ovf_sticky);
    end
    clr_sticky = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b, expected 1", ovf_sticky);
    end
    wait_drain();
  endtask

  // T5: reset with two beats in flight, then a clean beat afterwards
  task automatic test_reset_in_flight();
    out_ready = 1'b0;
    send(6'd10, 6'd20, ADD, 6'd30, 4'b0000);
    send(6'd1,  6'd1,  ADD, 6'd2,  4'b0000);
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_flight: valid=%b op_count=%0d, expected 0 0", out_valid, op_count);
    end
    out_ready = 1'b1;
    send(6'd5, 6'd3, ADD, 6'd8, 4'b0000);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_output: out_valid=%b after reset, expected 0", out_valid);
    end
    wait_drain();
    checks++;
    if (op_count !== 8'd1) begin
      errors++;
      $display("FAIL count_after_reset: got %0d, expected 1", op_count);
    end
  endtask

  // T4: 8 back-to-back beats with a 3-cycle consumer stall in the middle
  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_model(6'(i * 7 + 3), 6'(i * 5 + 1), 2'(i));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_drop: stall seen=%b, expected 1", saw_stall);
    end
    checks++;
    if (op_count !== 8'd8) begin
      errors++;
      $display("FAIL stream_count: got %0d, expected 8", op_count);
    end
  endtask

  // T6: 2-bit counter saturates at 3 after 5 completed beats
  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_model(6'(i + 1), 6'(i + 2), AND);
    end
    wait_drain();
    checks++;
    if (op_count2 !== 2'd3) begin
      errors++;
      $display("FAIL count_saturate: got %0d, expected 3", op_count2);
    end
    checks++;
    if (op_count !== 8'd5) begin
      errors++;
      $display("FAIL count_five: got %0d, expected 5", op_count);
    end
  endtask

  initial begin
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_op      = ADD;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    saw_stall  = 1'b0;
    test_reset();
    test_add();
    test_sub_logic();
    test_flags_sticky();
    test_reset_in_flight();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_exec_stage
